// File: rtl/interface_frame_writer.sv
// Host-side frame writer: turns connect/disconnect/send commands plus a handshaked
// payload stream into header, length and payload words for a downstream FIFO.
module interface_frame_writer #(
  parameter int DATA_W     = 8,
  parameter int HOST_AW    = 4,
  parameter int LEN_W      = 8,
  parameter int LEN_OFFSET = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               full_i,
  input  logic               connect_req_i,
  input  logic               disconnect_req_i,
  input  logic               send_req_i,
  input  logic [HOST_AW-1:0] host_addr_i,
  input  logic [LEN_W-1:0]   msg_len_i,
  input  logic [DATA_W-1:0]  msg_data_i,
  input  logic               msg_valid_i,
  output logic               msg_ready_o,
  output logic               cmd_ack_o,
  output logic               done_o,
  output logic               busy_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               writereq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD
  } state_t;

  localparam logic [2:0] OP_CONNECT    = 3'b000;
  localparam logic [2:0] OP_DISCONNECT = 3'b001;
  localparam logic [2:0] OP_SEND       = 3'b010;

  state_t              state, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   data_d;
  logic                wr_d, ack_d, done_d;

  // Header word: opcode in the low bits, host address above it, zero padding on top.
  function automatic logic [DATA_W-1:0] header(input logic [HOST_AW-1:0] host,
                                               input logic [2:0] op);
    logic [DATA_W-1:0] h;
    h = '0;
    h[HOST_AW+2:0] = {host, op};
    return h;
  endfunction

  assign msg_ready_o = (state == S_PAYLOAD) && !full_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state;
    len_d   = len_q;
    rem_d   = rem_q;
    data_d  = data_o;
    wr_d    = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!full_i) begin
          if (connect_req_i) begin
            data_d = header(host_addr_i, OP_CONNECT);
            wr_d   = 1'b1;
            ack_d  = 1'b1;
          end else if (disconnect_req_i) begin
            data_d = header(host_addr_i, OP_DISCONNECT);
            wr_d   = 1'b1;
            ack_d  = 1'b1;
          end else if (send_req_i) begin
            data_d  = header(host_addr_i, OP_SEND);
            wr_d    = 1'b1;
            ack_d   = 1'b1;
            len_d   = msg_len_i;
            state_d = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (!full_i) begin
          // Length word wraps modulo 2^DATA_W.
          data_d = DATA_W'(len_q) + DATA_W'(LEN_OFFSET);
          wr_d   = 1'b1;
          if (len_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d   = len_q;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (msg_ready_o && msg_valid_i) begin
          data_d = msg_data_i;
          wr_d   = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: asynchronous reset clears state and every registered output, aborting any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      data_o     <= '0;
      writereq_o <= 1'b0;
      cmd_ack_o  <= 1'b0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state      <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      data_o     <= data_d;
      writereq_o <= wr_d;
      cmd_ack_o  <= ack_d;
      done_o     <= done_d;
      busy_o     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_interface_frame_writer.sv
// Self-checking bench for interface_frame_writer: an ordered expected-write queue
// checked every cycle, plus literal checks on headers, lengths, timing and reset.
module tb_interface_frame_writer;

  localparam int DATA_W  = 8;
  localparam int HOST_AW = 4;
  localparam int LEN_W   = 8;
  localparam int TMO     = 60;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               full_i = 1'b0;
  logic               connect_req_i = 1'b0;
  logic               disconnect_req_i = 1'b0;
  logic               send_req_i = 1'b0;
  logic [HOST_AW-1:0] host_addr_i = '0;
  logic [LEN_W-1:0]   msg_len_i = '0;
  logic [DATA_W-1:0]  msg_data_i = '0;
  logic               msg_valid_i = 1'b0;
  logic               msg_ready_o, cmd_ack_o, done_o, busy_o, writereq_o;
  logic [DATA_W-1:0]  data_o;

  interface_frame_writer #(
    .DATA_W(DATA_W), .HOST_AW(HOST_AW), .LEN_W(LEN_W), .LEN_OFFSET(21)
  ) dut (
    .clk(clk), .rst(rst), .full_i(full_i),
    .connect_req_i(connect_req_i), .disconnect_req_i(disconnect_req_i),
    .send_req_i(send_req_i), .host_addr_i(host_addr_i), .msg_len_i(msg_len_i),
    .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .cmd_ack_o(cmd_ack_o), .done_o(done_o), .busy_o(busy_o),
    .data_o(data_o), .writereq_o(writereq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  logic       wr_done[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       prev_full = 1'b1;
  logic [7:0] payload[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_exp(input logic [7:0] d, input logic a, input logic dn);
    exp_t e;
    e.data = d; e.ack = a; e.done = dn;
    exp_q.push_back(e);
  endfunction

  // Header per command: host address times 8 plus opcode.
  function automatic logic [7:0] hdr(input int addr, input int op);
    return 8'((addr * 8 + op) % 256);
  endfunction

  // Per-cycle compare against the ordered expected-write queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_full = full_i;
    end else begin
      if (writereq_o) begin
        check("write_after_full", {31'b0, prev_full}, 0);
        wr_data.push_back(data_o);
        wr_cyc.push_back(cyc);
        wr_done.push_back(done_o);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_data", {24'b0, data_o}, {24'b0, e.data});
          check("write_ack", {31'b0, cmd_ack_o}, {31'b0, e.ack});
          check("write_done", {31'b0, done_o}, {31'b0, e.done});
        end
      end else begin
        check("ack_without_write", {31'b0, cmd_ack_o}, 0);
        check("done_without_write", {31'b0, done_o}, 0);
      end
      if (full_i) check("ready_while_full", {31'b0, msg_ready_o}, 0);
      prev_full = full_i;
    end
  end

  task automatic wait_ack();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ack_o && t < TMO);
    if (!cmd_ack_o) check("ack_timeout", 0, 1);
  endtask

  task automatic produce_word(input logic [7:0] d);
    int t = 0;
    msg_data_i  = d;
    msg_valid_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!msg_ready_o && t < TMO);
    if (!msg_ready_o) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int addr, input int len, input bit stall);
    push_exp(hdr(addr, 2), 1'b1, 1'b0);
    push_exp(8'((len + 21) % 256), 1'b0, len == 0);
    for (int i = 0; i < len; i++) push_exp(payload[i], 1'b0, i == len - 1);
    @(posedge clk); #1;
    send_req_i  = 1'b1;
    host_addr_i = HOST_AW'(addr);
    msg_len_i   = LEN_W'(len);
    wait_ack();
    send_req_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      produce_word(payload[i]);
      if (stall && i == 0) begin
        full_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 full_i = 1'b0;
      end
    end
    msg_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    #1;
    check("rst_writereq", {31'b0, writereq_o}, 0);
    check("rst_data", {24'b0, data_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_ready", {31'b0, msg_ready_o}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Test 1: connect to host 5
    push_exp(8'h28, 1'b1, 1'b0);
    @(posedge clk); #1;
    connect_req_i = 1'b1;
    host_addr_i   = 4'd5;
    wait_ack();
    connect_req_i = 1'b0;
    #1;
    check("t1_data", {24'b0, data_o}, 32'h28);
    check("t1_writereq", {31'b0, writereq_o}, 1);
    check("t1_busy", {31'b0, busy_o}, 0);

    // Test 2: connect beats disconnect, then disconnect follows
    push_exp(8'h18, 1'b1, 1'b0);
    push_exp(8'h19, 1'b1, 1'b0);
    @(posedge clk); #1;
    connect_req_i    = 1'b1;
    disconnect_req_i = 1'b1;
    host_addr_i      = 4'd3;
    wait_ack();
    connect_req_i = 1'b0;
    check("t2_connect_hdr", {24'b0, data_o}, 32'h18);
    wait_ack();
    disconnect_req_i = 1'b0;
    check("t2_disconnect_hdr", {24'b0, data_o}, 32'h19);

    // Payload presented in IDLE must not be consumed
    @(posedge clk); #1;
    msg_data_i  = 8'h55;
    msg_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", {31'b0, msg_ready_o}, 0);
    end
    msg_valid_i = 1'b0;

    // Test 3: send 3 bytes back-to-back
    payload = '{8'hAA, 8'hBB, 8'hCC};
    base = wr_data.size();
    send_frame(2, 3, 1'b0);
    check("t3_count", wr_data.size() - base, 5);
    check("t3_hdr", {24'b0, wr_data[base]}, 32'h12);
    check("t3_len", {24'b0, wr_data[base+1]}, 24);
    check("t3_last", {24'b0, wr_data[base+4]}, 32'hCC);
    check("t3_span", wr_cyc[base+4] - wr_cyc[base], 4);
    check("t3_done_on_cc", {31'b0, wr_done[base+4]}, 1);
    check("t3_idle", {31'b0, busy_o}, 0);

    // Test 4: same frame with a 2-cycle full stall during payload
    base = wr_data.size();
    send_frame(2, 3, 1'b1);
    check("t4_count", wr_data.size() - base, 5);
    check("t4_mid", {24'b0, wr_data[base+3]}, 32'hBB);
    check("t4_span", wr_cyc[base+4] - wr_cyc[base], 6);
    check("t4_done_on_cc", {31'b0, wr_done[base+4]}, 1);

    // Test 5: zero-length and wrapping length
    payload.delete();
    base = wr_data.size();
    send_frame(1, 0, 1'b0);
    check("t5_count0", wr_data.size() - base, 2);
    check("t5_len0", {24'b0, wr_data[base+1]}, 21);
    check("t5_done0", {31'b0, wr_done[base+1]}, 1);
    check("t5_idle0", {31'b0, busy_o}, 0);
    for (int i = 0; i < 240; i++) payload.push_back(8'(i * 7 + 3));
    base = wr_data.size();
    send_frame(9, 240, 1'b0);
    check("t5_len240", {24'b0, wr_data[base+1]}, 5);
    check("t5_count240", wr_data.size() - base, 242);

    // Test 6: asynchronous reset after the 2nd payload word
    push_exp(hdr(6, 2), 1'b1, 1'b0);
    push_exp(8'd25, 1'b0, 1'b0);
    push_exp(8'h11, 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    send_req_i  = 1'b1;
    host_addr_i = 4'd6;
    msg_len_i   = 8'd4;
    wait_ack();
    send_req_i = 1'b0;
    produce_word(8'h11);
    produce_word(8'h22);
    msg_valid_i = 1'b0;
    @(negedge clk); #1;
    check("t6_busy_before", {31'b0, busy_o}, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_writereq", {31'b0, writereq_o}, 0);
    check("t6_data", {24'b0, data_o}, 0);
    check("t6_busy", {31'b0, busy_o}, 0);
    check("t6_done", {31'b0, done_o}, 0);
    check("t6_ready", {31'b0, msg_ready_o}, 0);
    check("t6_exp_drained", exp_q.size(), 0);
    @(posedge clk); #2 rst = 1'b0;
    push_exp(8'h28, 1'b1, 1'b0);
    @(posedge clk); #1;
    connect_req_i = 1'b1;
    host_addr_i   = 4'd5;
    wait_ack();
    connect_req_i = 1'b0;
    check("t6_reconnect", {24'b0, data_o}, 32'h28);

    repeat (4) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
